// File: rtl/screen_pkg.sv
// Shared screen geometry, colours and plot_queue types.
// Imported by the plot_queue slice and its bench.
package screen_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PIX_W    = 18;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } pq_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

endpackage

// File: rtl/plot_queue_if.sv
// Pixel bus between draw controller, plot_queue and VGA adapter.
// master: draw/adapter side; slave: plot_queue.
interface plot_queue_if;

  logic       in_valid;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_ready;
  logic       out_enable;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;

  modport master (
    output in_valid, in_x, in_y, in_colour, out_enable,
    input  in_ready, out_x, out_y, out_colour, out_plot
  );

  modport slave (
    input  in_valid, in_x, in_y, in_colour, out_enable,
    output in_ready, out_x, out_y, out_colour, out_plot
  );

endinterface

// File: rtl/pixel_fifo.sv
// DEPTH x 18 pixel FIFO; head is readable in the same cycle.
// Ports: clock, reset, push, pop, wdata, rdata, count.
module pixel_fifo
  import screen_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  pixel_t        wdata,
  output pixel_t        rdata,
  output logic [AW:0]   count
);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/plot_queue.sv
// Clipping pixel queue with a full-screen clear sweep.
// Ports: clock, reset, pq (slave), clear_req/colour/busy, count, drop_count.
module plot_queue
  import screen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  plot_queue_if.slave   pq,
  input  logic          clear_req,
  input  logic [2:0]    clear_colour,
  output logic          clear_busy,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_count
);

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [7:0]    X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0]    Y_LAST = 7'(Y_MAX - 1);

  pq_state_t  state;
  pq_state_t  state_n;
  pixel_t     wr_pix;
  pixel_t     head;
  logic       accept;
  logic       clip;
  logic       push;
  logic       pop;
  logic       clear_go;
  logic       sweep_last;
  logic [7:0] sx;
  logic [6:0] sy;
  logic [2:0] clr_colour;

  assign pq.in_ready = (state == PASS) && (count != FULL);
  assign accept      = pq.in_valid && pq.in_ready;
  assign clip        = (pq.in_x > X_LAST) || (pq.in_y > Y_LAST);
  assign push        = accept && !clip;
  assign pop         = pq.out_enable && (count != '0) && (state != CLEAR);
  assign clear_go    = (state == PASS) && clear_req;
  assign sweep_last  = (sx == X_LAST) && (sy == Y_LAST);
  assign clear_busy  = (state != PASS);
  assign wr_pix      = {pq.in_x, pq.in_y, pq.in_colour};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pix),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      PASS:    if (clear_req) state_n = DRAIN;
      DRAIN:   if (count == '0) state_n = CLEAR;
      CLEAR:   if (pq.out_enable && sweep_last) state_n = PASS;
      default: state_n = PASS;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= PASS;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pq.out_x      <= '0;
      pq.out_y      <= '0;
      pq.out_colour <= '0;
      pq.out_plot   <= 1'b0;
      drop_count    <= '0;
      sx            <= '0;
      sy            <= '0;
      clr_colour    <= '0;
    end else begin
      pq.out_plot <= 1'b0;
      if (clear_go) begin
        clr_colour <= clear_colour;
        sx         <= '0;
        sy         <= '0;
      end
      if (accept && clip && (drop_count != 8'hFF))
        drop_count <= drop_count + 1'b1;
      if (pop) begin
        pq.out_x      <= head.x;
        pq.out_y      <= head.y;
        pq.out_colour <= head.colour;
        pq.out_plot   <= 1'b1;
      end else if ((state == CLEAR) && pq.out_enable) begin
        pq.out_x      <= sx;
        pq.out_y      <= sy;
        pq.out_colour <= clr_colour;
        pq.out_plot   <= 1'b1;
        // raster order: x fastest, wrap back to origin after the last pixel
        if (sx == X_LAST) begin
          sx <= '0;
          sy <= sweep_last ? '0 : sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_queue.sv
// Directed bench for plot_queue with an expected-pixel scoreboard.
// Monitor pops the scoreboard on every out_plot.
module tb_plot_queue;
  import screen_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic [2:0] clear_colour = 3'b000;
  logic       clear_busy;
  logic [4:0] count;
  logic [7:0] drop_count;

  plot_queue_if pq ();

  plot_queue #(.DEPTH(16), .X_MAX(160), .Y_MAX(120)) dut (
    .clock        (clock),
    .reset        (reset),
    .pq           (pq.slave),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .count        (count),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int         passed = 0;
  int         total = 0;
  int         plots = 0;
  int         p0;
  logic       found;
  pixel_t     sb[$];
  pixel_t     mon_exp;
  logic [7:0] last_x = '0;
  logic [6:0] last_y = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(posedge clock) begin
    #1;
    if (pq.out_plot === 1'b1) begin
      plots++;
      last_x = pq.out_x;
      last_y = pq.out_y;
      if (sb.size() == 0) begin
        chk("unexpected_plot", 32'(pq.out_plot), 0);
      end else begin
        mon_exp = sb.pop_front();
        chk("plot_pixel", 32'({pq.out_x, pq.out_y, pq.out_colour}),
            32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int x, input int y, input int c);
    @(negedge clock);
    pq.in_valid  = 1'b1;
    pq.in_x      = 8'(x);
    pq.in_y      = 7'(y);
    pq.in_colour = 3'(c);
    if (pq.in_ready && x < 160 && y < 120)
      sb.push_back({8'(x), 7'(y), 3'(c)});
    @(posedge clock);
    #2;
    pq.in_valid = 1'b0;
  endtask

  task automatic expect_sweep(input logic [2:0] c);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        sb.push_back({8'(x), 7'(y), c});
  endtask

  initial begin
    pq.in_valid   = 1'b0;
    pq.in_x       = '0;
    pq.in_y       = '0;
    pq.in_colour  = '0;
    pq.out_enable = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_out_plot", 32'(pq.out_plot), 0);
    chk("rst_out_xyc", 32'({pq.out_x, pq.out_y, pq.out_colour}), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_in_ready", 32'(pq.in_ready), 1);
    reset = 1'b0;

    // single pixel latency
    pq.out_enable = 1'b1;
    send(5, 10, 7);
    chk("lat_not_early", 32'(pq.out_plot), 0);
    tick();
    chk("lat_plot", 32'(pq.out_plot), 1);
    chk("lat_xyc", 32'({pq.out_x, pq.out_y, pq.out_colour}),
        32'({8'd5, 7'd10, 3'd7}));
    chk("lat_count", 32'(count), 0);

    // fill to full, then drain without gaps
    @(negedge clock);
    pq.out_enable = 1'b0;
    for (int i = 0; i < 16; i++) send(i * 3, i + 2, i % 8);
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(pq.in_ready), 0);
    send(100, 100, 1);
    chk("full_held_count", 32'(count), 16);
    @(negedge clock);
    pq.out_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_nogap", 32'(pq.out_plot), 1);
    end
    tick();
    chk("drain_done_plot", 32'(pq.out_plot), 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);

    // clipping
    p0 = plots;
    send(255, 127, 0);
    send(160, 0, 7);
    send(0, 120, 7);
    repeat (3) tick();
    chk("clip_drop3", 32'(drop_count), 3);
    chk("clip_noplot", 32'(plots), 32'(p0));
    for (int i = 0; i < 300; i++) send(200 + (i % 50), i % 128, 1);
    chk("clip_saturate", 32'(drop_count), 255);

    // clear behind queued pixels
    @(negedge clock);
    pq.out_enable = 1'b0;
    send(7, 8, 1);
    send(9, 10, 2);
    send(11, 12, 3);
    @(negedge clock);
    clear_req = 1'b1;
    clear_colour = BLACK;
    expect_sweep(BLACK);
    @(negedge clock);
    clear_req = 1'b0;
    chk("clr_busy", 32'(clear_busy), 1);
    chk("clr_ready", 32'(pq.in_ready), 0);
    chk("clr_count", 32'(count), 3);
    p0 = plots;
    pq.out_enable = 1'b1;
    for (int i = 0; i < 20000 && sb.size() != 0; i++) begin
      tick();
      if (sb.size() == 1) chk("clr_busy_late", 32'(clear_busy), 1);
    end
    chk("clr_sb_empty", 32'(sb.size()), 0);
    chk("clr_plots", 32'(plots - p0), 19203);
    chk("clr_busy_fall", 32'(clear_busy), 0);
    chk("clr_ready_back", 32'(pq.in_ready), 1);

    // paused sweep with an ignored second request
    @(negedge clock);
    clear_req = 1'b1;
    clear_colour = 3'd5;
    expect_sweep(3'd5);
    @(negedge clock);
    clear_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      pq.out_enable = ~pq.out_enable;
      clear_req = (i == 101);
      clear_colour = (i == 101) ? 3'd3 : 3'd5;
    end
    @(negedge clock);
    clear_req = 1'b0;
    pq.out_enable = 1'b1;
    for (int i = 0; i < 20000 && sb.size() != 0; i++) tick();
    chk("pause_sb_empty", 32'(sb.size()), 0);
    chk("pause_busy_fall", 32'(clear_busy), 0);
    p0 = plots;
    repeat (5) tick();
    chk("pause_no_resweep", 32'(plots), 32'(p0));

    // reset mid-sweep at (40,60)
    @(negedge clock);
    clear_req = 1'b1;
    clear_colour = 3'd2;
    expect_sweep(3'd2);
    @(negedge clock);
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12000 && !found; i++) begin
      tick();
      if (last_x == 8'd40 && last_y == 7'd60) found = 1'b1;
    end
    chk("rst_mid_reached", 32'(found), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_plot", 32'(pq.out_plot), 0);
    chk("rst_mid_busy", 32'(clear_busy), 0);
    chk("rst_mid_count", 32'(count), 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(pq.in_ready), 1);
    p0 = plots;
    send(1, 1, 7);
    tick();
    tick();
    chk("post_rst_plots", 32'(plots - p0), 1);
    chk("post_rst_sb", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
